// File: rtl/bcd_serial_addsub_seq.sv
// Digit-serial N-digit packed-BCD add/subtract sequencer, one digit per clock, LSD first.
// Define BCD_SEQ_RECOMP_EN to recomplement negative differences to sign-magnitude.
module bcd_serial_addsub_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_out,
  output logic                  negative,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    RECOMP = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q;
  logic            mode_q;
  logic [IW-1:0]   idx;
  logic            carry;

  logic            accept, bad_in, last;
  logic [3:0]      x, y, digit;
  logic [4:0]      sum;
  logic            cout;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // One shared digit adder: ADD feeds a_i and (9's-complemented) b_i, RECOMP feeds 9-r_i.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    x      = 4'd0;
    y      = 4'd0;
    accept = start && (state == IDLE || state == DONE);
    bad_in = has_bad_digit(a) || has_bad_digit(b);
    last   = (idx == IW'(DIGITS - 1));
    if (state == RECOMP) begin
      x = 4'd9 - result[4*int'(idx) +: 4];
    end else begin
      x = a_q[4*int'(idx) +: 4];
      y = mode_q ? 4'd9 - b_q[4*int'(idx) +: 4] : b_q[4*int'(idx) +: 4];
    end
    sum   = {1'b0, x} + {1'b0, y} + {4'd0, carry};
    cout  = (sum > 5'd9);
    digit = cout ? sum[3:0] + 4'd6 : sum[3:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? (bad_in ? DONE : ADD) : IDLE;
      ADD: if (last) begin
        if (!mode_q || cout) state_nxt = DONE;
`ifdef BCD_SEQ_RECOMP_EN
        else                 state_nxt = RECOMP;
`else
        else                 state_nxt = DONE;
`endif
      end
`ifdef BCD_SEQ_RECOMP_EN
      RECOMP: if (last) state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: all registers, operand latches included, are reset so outputs read zero after rst.
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      invalid   <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      mode_q    <= mode;
      idx       <= '0;
      carry     <= mode;
      result    <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      invalid   <= bad_in;
    end else if (state == ADD) begin
      result[4*int'(idx) +: 4] <= digit;
      carry <= cout;
      idx   <= idx + 1'b1;
      if (last) begin
        carry_out <= cout;
        negative  <= mode_q & ~cout;
        idx       <= '0;
        carry     <= 1'b1;  // carry-in for the 10's-complement recomplement pass
      end
`ifdef BCD_SEQ_RECOMP_EN
    end else if (state == RECOMP) begin
      result[4*int'(idx) +: 4] <= digit;
      carry <= cout;
      idx   <= idx + 1'b1;
`endif
    end
  end

  assign busy = (state == ADD) || (state == RECOMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_addsub_seq.sv
// Scoreboard bench for bcd_serial_addsub_seq: integer reference model, randomized and directed stimulus.
module tb_bcd_serial_addsub_seq;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst, start, mode;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, negative, invalid;
  logic [W-1:0] result;

  bcd_serial_addsub_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .negative(negative), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    logic         neg;
    logic         inv;
    int           lat;
    int           k;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] ua, input logic [W-1:0] ub, input logic m);
    exp_t e;
    int   p = 10 ** D;
    int   va, vb;
    logic bad = 1'b0;
    for (int i = 0; i < D; i++)
      if (ua[4*i +: 4] > 4'd9 || ub[4*i +: 4] > 4'd9) bad = 1'b1;
    e.k = 0;
    if (bad) begin
      e.result = '0; e.carry = 1'b0; e.neg = 1'b0; e.inv = 1'b1; e.lat = 0;
      return e;
    end
    va = bcd2int(ua);
    vb = bcd2int(ub);
    e.inv = 1'b0;
    e.lat = D;
    if (!m) begin
      e.result = int2bcd((va + vb) % p);
      e.carry  = (va + vb >= p);
      e.neg    = 1'b0;
    end else if (va >= vb) begin
      e.result = int2bcd(va - vb);
      e.carry  = 1'b1;
      e.neg    = 1'b0;
    end else begin
      e.carry = 1'b0;
      e.neg   = 1'b1;
`ifdef BCD_SEQ_RECOMP_EN
      e.result = int2bcd(vb - va);
      e.lat    = 2 * D;
`else
      e.result = int2bcd(p + va - vb);
`endif
    end
    return e;
  endfunction

  // Called at a falling edge; the start pulse is sampled by the following rising edge.
  task automatic issue(input logic [W-1:0] ua, input logic [W-1:0] ub, input logic m);
    exp_t e;
    int   n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait_timeout", 32'(busy), 32'd0);
    a = ua; b = ub; mode = m; start = 1'b1;
    e   = model(ua, ub, m);
    e.k = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_carry_out"}, 32'(carry_out), 32'd0);
    check({tag, "_negative"},  32'(negative),  32'd0);
    check({tag, "_invalid"},   32'(invalid),   32'd0);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("result",    32'(result),    32'(e.result));
          check("carry_out", 32'(carry_out), 32'(e.carry));
          check("negative",  32'(negative),  32'(e.neg));
          check("invalid",   32'(invalid),   32'(e.inv));
          check("latency",   32'(cyc - e.k), 32'(e.lat));
          check("busy_at_done", 32'(busy),   32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    issue(16'h1234, 16'h5678, 1'b0);
    issue(16'h9999, 16'h0001, 1'b0);
    issue(16'h5000, 16'h1234, 1'b1);
    issue(16'h1234, 16'h1234, 1'b1);
    issue(16'h1234, 16'h5000, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1);
    issue(16'h12A4, 16'h0000, 1'b0);
    issue(16'h0042, 16'h0017, 1'b0);

    // Start pulses and operand changes while busy must not disturb the pass in flight.
    issue(16'h2468, 16'h1357, 1'b1);
    start = 1'b1; a = 16'h9999; b = 16'h9999; mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset two edges into a pass: no done pulse, everything back to zero.
    issue(16'h4321, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    void'(q.pop_back());
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    issue(16'h0500, 16'h0499, 1'b1);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
